// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI burst write receiver.
// FSM state encoding, opcode width and default write opcode.
package spi_rx_pkg;

  localparam int OP_W = 8;
  localparam logic [OP_W-1:0] CMD_WRITE_DEF = 8'hA4;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DISCARD
  } state_t;

endpackage

// File: rtl/spi_burst_receiver_if.sv
// Pin-side SPI inputs and register-file write port bundle.
// slave: receiver side; master: SPI master plus write sink side.
interface spi_burst_receiver_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);

  logic              sck;
  logic              cs;
  logic              copi;
  logic              wr_en_out;
  logic [ADDR_W-1:0] wr_address_out;
  logic [DATA_W-1:0] wr_data_out;
  logic              frame_err_out;

  modport slave (
    input  sck, cs, copi,
    output wr_en_out, wr_address_out,
    output wr_data_out, frame_err_out
  );

  modport master (
    output sck, cs, copi,
    input  wr_en_out, wr_address_out,
    input  wr_data_out, frame_err_out
  );

endinterface

// File: rtl/spi_rx_sync.sv
// Synchronises sck/cs/copi into clk and emits registered edge strobes.
// Ports: clk, rst, raw sck/cs/copi in; sck_rise, cs_fall, cs_rise, copi_s out.
module spi_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic cs,
  input  logic copi,
  output logic sck_rise,
  output logic cs_fall,
  output logic cs_rise,
  output logic copi_s
);

  logic [STAGES-1:0] sck_q;
  logic [STAGES-1:0] cs_q;
  logic [STAGES-1:0] copi_q;
  logic              sck_d;
  logic              cs_d;

  // The chain and edge history keep tracking the pins through reset so
  // that a reset inside a frame never manufactures a false cs edge.
  always_ff @(posedge clk) begin
    sck_q  <= {sck_q[STAGES-2:0], sck};
    cs_q   <= {cs_q[STAGES-2:0], cs};
    copi_q <= {copi_q[STAGES-2:0], copi};
    sck_d  <= sck_q[STAGES-1];
    cs_d   <= cs_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_rise <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
      copi_s   <= 1'b0;
    end else begin
      sck_rise <= sck_q[STAGES-1] & ~sck_d;
      cs_fall  <= ~cs_q[STAGES-1] & cs_d;
      cs_rise  <= cs_q[STAGES-1] & ~cs_d;
      copi_s   <= copi_q[STAGES-1];
    end
  end

endmodule

// File: rtl/spi_burst_receiver.sv
// SPI mode-0 write slave: opcode/address/data frames -> write strobes.
// Ports: clk, rst, bus (slave). SPI_RX_BURST_EN enables burst auto-increment.
module spi_burst_receiver
  import spi_rx_pkg::*;
#(
  parameter int              ADDR_W      = 24,
  parameter int              DATA_W      = 32,
  parameter logic [OP_W-1:0] CMD_WRITE   = CMD_WRITE_DEF,
  parameter int              SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst,
  spi_burst_receiver_if.slave  bus
);

  localparam int SHIFT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(SHIFT_W + 1);

  localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] shift_nx;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic               wr_en_q;
  logic               err_q;

  logic sck_rise;
  logic cs_fall;
  logic cs_rise;
  logic copi_s;
  logic word_done;
  logic cut_err;

  spi_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sck      (bus.sck),
    .cs       (bus.cs),
    .copi     (bus.copi),
    .sck_rise (sck_rise),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .copi_s   (copi_s)
  );

  assign shift_nx  = {shift_q[SHIFT_W-2:0], copi_s};
  assign word_done = (state_q == DATA) && sck_rise &&
                     (cnt_q == DATA_LAST);

  // A word finishing in the same cycle as cs rising still counts.
  always_comb begin
    cut_err = 1'b0;
    unique case (1'b1)
      state_q == CMD,
      state_q == ADDR: cut_err = cs_rise;
      state_q == DATA: cut_err = cs_rise & ~word_done &
                                 (sck_rise | (cnt_q != '0));
      default:         cut_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == IDLE) begin
        if (cs_fall) begin
          state_q <= CMD;
          cnt_q   <= '0;
        end
      end else begin
        if (sck_rise) begin
          shift_q <= shift_nx;
          cnt_q   <= cnt_q + CNT_W'(1);
          unique case (state_q)
            CMD: if (cnt_q == OP_LAST) begin
              cnt_q <= '0;
              if (shift_nx[OP_W-1:0] == CMD_WRITE) begin
                state_q <= ADDR;
              end else begin
                state_q <= DISCARD;
                err_q   <= 1'b1;
              end
            end
            ADDR: if (cnt_q == ADDR_LAST) begin
              cnt_q   <= '0;
              addr_q  <= shift_nx[ADDR_W-1:0];
              state_q <= DATA;
            end
            DATA: if (word_done) begin
              cnt_q     <= '0;
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= shift_nx[DATA_W-1:0];
`ifdef SPI_RX_BURST_EN
              addr_q    <= addr_q + ADDR_W'(1);
`else
              state_q   <= DISCARD;
`endif
            end
            default: cnt_q <= '0;
          endcase
        end
        // cs rising ends the frame from any active state.
        if (cs_rise) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          if (cut_err) err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.wr_en_out      = wr_en_q;
  assign bus.wr_address_out = wr_addr_q;
  assign bus.wr_data_out    = wr_data_q;
  assign bus.frame_err_out  = err_q;

endmodule
